dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 31 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side port bundle (CPU or debug/loader) and the single-port data-memory bundle.
// Requesters hold req/we/addr/wdata until gnt; reads answer through rvalid/rdata one cycle later.
interface dmem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output read, write, addr, wdata, input  rdata);
    modport slave  (input  read, write, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto one single-port data memory: combinational grant, 1-cycle read latency.
// Losing port stalls by holding its request; round-robin or fixed priority with x starvation guard.
module dmem_arbiter #(
    parameter int AW           = 6,
    parameter int DW           = 32,
    parameter int RR           = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   d,
    dmem_arbiter_if.slave   x,
    dmem_mem_if.master      mem
);
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic          r_last_x;
    logic [3:0]    r_starve;
    logic          r_d_rvalid;
    logic          r_x_rvalid;
    logic [DW-1:0] r_d_rdata;
    logic [DW-1:0] r_x_rdata;

    logic          w_x_prio;
    logic          w_d_gnt;
    logic          w_x_gnt;

    // x takes a tie when d won last (round-robin) or when x has starved long enough (fixed).
    always_comb begin
        w_x_prio = 1'b0;
        if (RR != 0) begin
            w_x_prio = ~r_last_x;
        end else begin
            w_x_prio = (r_starve == LP_LIMIT);
        end
        w_d_gnt = rst & d.req & ~(x.req & w_x_prio);
        w_x_gnt = rst & x.req & ~w_d_gnt;
    end

    always_comb begin
        mem.read  = 1'b0;
        mem.write = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        if (w_d_gnt) begin
            mem.read  = ~d.we;
            mem.write = d.we;
            mem.addr  = d.addr;
            mem.wdata = d.wdata;
        end else if (w_x_gnt) begin
            mem.read  = ~x.we;
            mem.write = x.we;
            mem.addr  = x.addr;
            mem.wdata = x.wdata;
        end
    end

    // Reset also drops any read response still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_x   <= 1'b1;
            r_starve   <= '0;
            r_d_rvalid <= 1'b0;
            r_x_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_x_rdata  <= '0;
        end else begin
            if (w_d_gnt) begin
                r_last_x <= 1'b0;
            end else if (w_x_gnt) begin
                r_last_x <= 1'b1;
            end

            if (w_x_gnt) begin
                r_starve <= '0;
            end else if (x.req && (r_starve != LP_LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end

            r_d_rvalid <= w_d_gnt & ~d.we;
            r_x_rvalid <= w_x_gnt & ~x.we;
            if (w_d_gnt && !d.we) begin
                r_d_rdata <= mem.rdata;
            end
            if (w_x_gnt && !x.we) begin
                r_x_rdata <= mem.rdata;
            end
        end
    end

    assign d.gnt    = w_d_gnt;
    assign x.gnt    = w_x_gnt;
    assign d.rvalid = r_d_rvalid;
    assign x.rvalid = r_x_rvalid;
    assign d.rdata  = r_d_rdata;
    assign x.rdata  = r_x_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: one round-robin arbiter and one fixed-priority arbiter, each with its own memory.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(6), .DW(32)) rr_d ();
    dmem_arbiter_if #(.AW(6), .DW(32)) rr_x ();
    dmem_mem_if     #(.AW(6), .DW(32)) rr_m ();
    dmem_arbiter_if #(.AW(6), .DW(32)) fp_d ();
    dmem_arbiter_if #(.AW(6), .DW(32)) fp_x ();
    dmem_mem_if     #(.AW(6), .DW(32)) fp_m ();

    dmem_arbiter #(.AW(6), .DW(32), .RR(1), .STARVE_LIMIT(4)) u_rr (
        .clk(clk), .rst(rst), .d(rr_d), .x(rr_x), .mem(rr_m)
    );
    dmem_arbiter #(.AW(6), .DW(32), .RR(0), .STARVE_LIMIT(4)) u_fp (
        .clk(clk), .rst(rst), .d(fp_d), .x(fp_x), .mem(fp_m)
    );

    logic [31:0] mem_rr [64];
    logic [31:0] mem_fp [64];
    assign rr_m.rdata = mem_rr[rr_m.addr];
    assign fp_m.rdata = mem_fp[fp_m.addr];
    always @(posedge clk) begin
        if (rr_m.write) mem_rr[rr_m.addr] <= rr_m.wdata;
        if (fp_m.write) mem_fp[fp_m.addr] <= fp_m.wdata;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_d_drv(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        rr_d.req = req; rr_d.we = we; rr_d.addr = a; rr_d.wdata = wd;
    endtask
    task automatic rr_x_drv(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        rr_x.req = req; rr_x.we = we; rr_x.addr = a; rr_x.wdata = wd;
    endtask
    task automatic fp_d_drv(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        fp_d.req = req; fp_d.we = we; fp_d.addr = a; fp_d.wdata = wd;
    endtask
    task automatic fp_x_drv(input logic req, input logic we, input logic [5:0] a, input logic [31:0] wd);
        fp_x.req = req; fp_x.we = we; fp_x.addr = a; fp_x.wdata = wd;
    endtask

    initial begin
        logic xw;
        for (int i = 0; i < 64; i++) begin
            mem_rr[i] = '0;
            mem_fp[i] = '0;
        end
        rst = 1'b0;
        rr_d_drv(1'b1, 1'b0, 6'd5, 32'h0);
        rr_x_drv(1'b1, 1'b0, 6'd6, 32'h0);
        fp_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        fp_x_drv(1'b0, 1'b0, 6'd0, 32'h0);

        // Reset state with requests pending
        repeat (2) step();
        #1;
        check("rst_d_gnt",    32'(rr_d.gnt), 0);
        check("rst_x_gnt",    32'(rr_x.gnt), 0);
        check("rst_mem_read", 32'(rr_m.read), 0);
        check("rst_mem_wr",   32'(rr_m.write), 0);
        check("rst_mem_addr", 32'(rr_m.addr), 0);
        check("rst_d_rvalid", 32'(rr_d.rvalid), 0);
        check("rst_x_rvalid", 32'(rr_x.rvalid), 0);
        check("rst_d_rdata",  rr_d.rdata, 0);
        check("rst_x_rdata",  rr_x.rdata, 0);

        // Write then read back addr 5 on d
        step();
        rst = 1'b1;
        rr_x_drv(1'b0, 1'b0, 6'd0, 32'h0);
        rr_d_drv(1'b1, 1'b1, 6'd5, 32'hA5A5_0011);
        #1;
        check("wr_d_gnt",     32'(rr_d.gnt), 1);
        check("wr_mem_write", 32'(rr_m.write), 1);
        check("wr_mem_read",  32'(rr_m.read), 0);
        check("wr_mem_addr",  32'(rr_m.addr), 5);
        check("wr_mem_wdata", rr_m.wdata, 32'hA5A5_0011);
        step();
        check("wr_no_rvalid", 32'(rr_d.rvalid), 0);
        rr_d_drv(1'b1, 1'b0, 6'd5, 32'h0);
        #1;
        check("rd_d_gnt",     32'(rr_d.gnt), 1);
        check("rd_mem_read",  32'(rr_m.read), 1);
        check("rd_mem_write", 32'(rr_m.write), 0);
        step();
        check("rd_rvalid",    32'(rr_d.rvalid), 1);
        check("rd_rdata",     rr_d.rdata, 32'hA5A5_0011);
        rr_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        #1;
        check("idle_mem_read", 32'(rr_m.read), 0);
        check("idle_mem_addr", 32'(rr_m.addr), 0);
        check("idle_d_gnt",    32'(rr_d.gnt), 0);
        step();
        check("rvalid_drop", 32'(rr_d.rvalid), 0);
        check("rdata_hold",  rr_d.rdata, 32'hA5A5_0011);

        // Preload addr 1 via d, addr 2 via lone x
        rr_d_drv(1'b1, 1'b1, 6'd1, 32'h1111_1111);
        #1;
        check("pre_d_gnt", 32'(rr_d.gnt), 1);
        step();
        rr_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        rr_x_drv(1'b1, 1'b1, 6'd2, 32'h2222_2222);
        #1;
        check("lone_x_gnt", 32'(rr_x.gnt), 1);
        step();

        // Round-robin: both read continuously, x won last so d starts
        rr_d_drv(1'b1, 1'b0, 6'd1, 32'h0);
        rr_x_drv(1'b1, 1'b0, 6'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_d_gnt", 32'(rr_d.gnt), (k % 2 == 0) ? 1 : 0);
            check("rr_x_gnt", 32'(rr_x.gnt), (k % 2 == 1) ? 1 : 0);
            step();
            check("rr_d_rvalid", 32'(rr_d.rvalid), (k % 2 == 0) ? 1 : 0);
            check("rr_x_rvalid", 32'(rr_x.rvalid), (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) check("rr_d_rdata", rr_d.rdata, 32'h1111_1111);
            else            check("rr_x_rdata", rr_x.rdata, 32'h2222_2222);
        end

        // d write and x read to addr 63 collide; d favored, x sees new data
        rr_d_drv(1'b1, 1'b1, 6'd63, 32'hDEAD_BEEF);
        rr_x_drv(1'b1, 1'b0, 6'd63, 32'h0);
        #1;
        check("raw_d_gnt",  32'(rr_d.gnt), 1);
        check("raw_x_gnt",  32'(rr_x.gnt), 0);
        check("raw_mem_wr", 32'(rr_m.write), 1);
        step();
        check("raw_d_no_rvalid", 32'(rr_d.rvalid), 0);
        rr_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        #1;
        check("raw_x_gnt2",    32'(rr_x.gnt), 1);
        check("raw_mem_read",  32'(rr_m.read), 1);
        step();
        check("raw_x_rvalid", 32'(rr_x.rvalid), 1);
        check("raw_x_rdata",  rr_x.rdata, 32'hDEAD_BEEF);
        rr_x_drv(1'b0, 1'b0, 6'd0, 32'h0);

        // Reset lands between a read grant and its response
        rr_d_drv(1'b1, 1'b0, 6'd5, 32'h0);
        #1;
        check("rab_d_gnt", 32'(rr_d.gnt), 1);
        #2;
        rst = 1'b0;
        rr_x_drv(1'b1, 1'b1, 6'd7, 32'h77);
        #1;
        check("rab_d_gnt_rst",  32'(rr_d.gnt), 0);
        check("rab_x_gnt_rst",  32'(rr_x.gnt), 0);
        check("rab_mem_rd_rst", 32'(rr_m.read), 0);
        check("rab_mem_wr_rst", 32'(rr_m.write), 0);
        step();
        check("rab_d_rvalid", 32'(rr_d.rvalid), 0);
        check("rab_d_rdata",  rr_d.rdata, 0);
        check("rab_x_rdata",  rr_x.rdata, 0);
        rst = 1'b1;
        rr_d_drv(1'b1, 1'b1, 6'd8, 32'h88);
        #1;
        check("post_rst_d_gnt", 32'(rr_d.gnt), 1);
        check("post_rst_x_gnt", 32'(rr_x.gnt), 0);
        step();
        check("post_rst_d_rvalid", 32'(rr_d.rvalid), 0);
        check("post_rst_x_rvalid", 32'(rr_x.rvalid), 0);
        rr_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        rr_x_drv(1'b0, 1'b0, 6'd0, 32'h0);

        // Fixed priority: x wins every 5th cycle under contention
        fp_d_drv(1'b1, 1'b1, 6'd3, 32'hD);
        fp_x_drv(1'b1, 1'b1, 6'd4, 32'hE);
        for (int c = 0; c < 10; c++) begin
            xw = (c == 4) || (c == 9);
            #1;
            check("fp_d_gnt", 32'(fp_d.gnt), xw ? 0 : 1);
            check("fp_x_gnt", 32'(fp_x.gnt), xw ? 1 : 0);
            step();
        end

        // Starvation count holds while x_req is low
        for (int c = 0; c < 2; c++) begin
            #1;
            check("fp_hold_pre", 32'(fp_x.gnt), 0);
            step();
        end
        fp_x_drv(1'b0, 1'b0, 6'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("fp_gap_d_gnt", 32'(fp_d.gnt), 1);
            step();
        end
        fp_x_drv(1'b1, 1'b1, 6'd4, 32'hE);
        for (int c = 0; c < 3; c++) begin
            xw = (c == 2);
            #1;
            check("fp_resume_x_gnt", 32'(fp_x.gnt), xw ? 1 : 0);
            check("fp_resume_d_gnt", 32'(fp_d.gnt), xw ? 0 : 1);
            step();
        end
        fp_d_drv(1'b0, 1'b0, 6'd0, 32'h0);
        fp_x_drv(1'b0, 1'b0, 6'd0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
